// File: rtl/vga_term_ctrl.sv
// vga_term_ctrl - terminal sequencer in front of vga_char's write port.
//
// Takes a byte stream over a valid/ready handshake, interprets a small set
// of control codes and turns printable bytes into explicit set-X / set-Y /
// char-write bus cycles. The cursor is owned here, so vga_char's own
// auto-increment is never relied upon. The first byte after reset first
// selects the main charset and clears the screen (leaving the splash).
//
// Ports:
//   clk_i        system clock (also vga_char wb_clk)
//   rst_i        synchronous active-high reset
//   rx_data_i    incoming byte
//   rx_valid_i   rx_data_i valid
//   rx_ready_o   controller can accept a byte (only in IDLE)
//   wb_cyc_o     one-cycle write strobe
//   wb_we_o      equals wb_cyc_o
//   wb_addr_o    000 char, 001 X, 011 Y, 110 charset select
//   wb_dat_o     write data
//   cursor_x_o   current column
//   cursor_y_o   current row
//   busy_o       sequence in progress (~rx_ready_o)
module vga_term_ctrl #(
  parameter int          COLS     = 64,
  parameter int          ROWS     = 32,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic       wb_cyc_o,
  output logic       wb_we_o,
  output logic [2:0] wb_addr_o,
  output logic [7:0] wb_dat_o,
  output logic [5:0] cursor_x_o,
  output logic [4:0] cursor_y_o,
  output logic       busy_o
);

  localparam logic [5:0] XMAX = 6'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  localparam logic [2:0] A_CH  = 3'b000;
  localparam logic [2:0] A_X   = 3'b001;
  localparam logic [2:0] A_Y   = 3'b011;
  localparam logic [2:0] A_SEL = 3'b110;

  // Each non-IDLE state names the write that is on the bus during it.
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CX, S_CY, S_CW, S_PX, S_PY, S_PW
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [5:0] sx_q, sx_d;
  logic [4:0] sy_q, sy_d;
  logic [7:0] byte_q, byte_d;
  logic       bs_q, bs_d;
  logic       pend_q, pend_d;
  logic       splash_q, splash_d;
  logic       rdy_q, rdy_d;
  logic       cyc_q, cyc_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] dat_q, dat_d;

  // Byte dispatch inputs: either a fresh accept or the byte held back
  // while the splash clear ran.
  logic       disp;
  logic       disp_clr;
  logic [7:0] db;
  logic [5:0] dx;
  logic [4:0] dy;
  logic [5:0] sx_n;
  logic [4:0] sy_n;
  logic       scan_last;

  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == YMAX) ? 5'd0 : r + 5'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      byte_q   <= '0;
      bs_q     <= 1'b0;
      pend_q   <= 1'b0;
      splash_q <= 1'b0;
      rdy_q    <= 1'b1;
      cyc_q    <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      byte_q   <= byte_d;
      bs_q     <= bs_d;
      pend_q   <= pend_d;
      splash_q <= splash_d;
      rdy_q    <= rdy_d;
      cyc_q    <= cyc_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    byte_d   = byte_q;
    bs_d     = bs_q;
    pend_d   = pend_q;
    splash_d = splash_q;
    rdy_d    = rdy_q;
    cyc_d    = 1'b0;
    addr_d   = addr_q;
    dat_d    = dat_q;
    disp     = 1'b0;
    disp_clr = 1'b0;
    db       = rx_data_i;
    dx       = x_q;
    dy       = y_q;

    scan_last = (sx_q == XMAX) && (sy_q == YMAX);
    if (sx_q == XMAX) begin
      sx_n = 6'd0;
      sy_n = sy_q + 5'd1;
    end else begin
      sx_n = sx_q + 6'd1;
      sy_n = sy_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i && rdy_q) begin
          if (!splash_q) begin
            // Hold the byte until charset select and clear are done.
            byte_d  = rx_data_i;
            pend_d  = 1'b1;
            rdy_d   = 1'b0;
            cyc_d   = 1'b1;
            addr_d  = A_SEL;
            dat_d   = 8'h00;
            state_d = S_SEL;
          end else begin
            disp = 1'b1;
          end
        end
      end
      S_SEL: begin
        sx_d    = '0;
        sy_d    = '0;
        cyc_d   = 1'b1;
        addr_d  = A_X;
        dat_d   = 8'h00;
        state_d = S_CX;
      end
      S_CX: begin
        cyc_d   = 1'b1;
        addr_d  = A_Y;
        dat_d   = {3'b000, sy_q};
        state_d = S_CY;
      end
      S_CY: begin
        cyc_d   = 1'b1;
        addr_d  = A_CH;
        dat_d   = CLR_CHAR;
        state_d = S_CW;
      end
      S_CW: begin
        if (scan_last) begin
          x_d      = '0;
          y_d      = '0;
          splash_d = 1'b1;
          rdy_d    = 1'b1;
          state_d  = S_IDLE;
          if (pend_q) begin
            // Held byte is processed with the freshly homed cursor.
            pend_d   = 1'b0;
            disp     = 1'b1;
            disp_clr = 1'b1;
            db       = byte_q;
            dx       = '0;
            dy       = '0;
          end
        end else begin
          sx_d    = sx_n;
          sy_d    = sy_n;
          cyc_d   = 1'b1;
          addr_d  = A_X;
          dat_d   = {2'b00, sx_n};
          state_d = S_CX;
        end
      end
      S_PX: begin
        cyc_d   = 1'b1;
        addr_d  = A_Y;
        dat_d   = {3'b000, y_q};
        state_d = S_PY;
      end
      S_PY: begin
        cyc_d   = 1'b1;
        addr_d  = A_CH;
        dat_d   = byte_q;
        state_d = S_PW;
      end
      S_PW: begin
        // Backspace already moved the cursor at accept.
        if (!bs_q) begin
          if (x_q == XMAX) begin
            x_d = '0;
            y_d = next_row(y_q);
          end else begin
            x_d = x_q + 6'd1;
          end
        end
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (disp) begin
      if (db == 8'h0D) begin
        x_d = '0;
      end else if (db == 8'h0A) begin
        y_d = next_row(dy);
      end else if (db == 8'h08) begin
        if (dx != 6'd0) begin
          x_d     = dx - 6'd1;
          bs_d    = 1'b1;
          byte_d  = CLR_CHAR;
          rdy_d   = 1'b0;
          cyc_d   = 1'b1;
          addr_d  = A_X;
          dat_d   = {2'b00, dx - 6'd1};
          state_d = S_PX;
        end
      end else if (db == 8'h0C) begin
        // A form feed that triggered the splash clear is not cleared twice.
        if (!disp_clr) begin
          sx_d    = '0;
          sy_d    = '0;
          rdy_d   = 1'b0;
          cyc_d   = 1'b1;
          addr_d  = A_X;
          dat_d   = 8'h00;
          state_d = S_CX;
        end
      end else if (db >= 8'h20 && db != 8'h7F) begin
        byte_d  = db;
        bs_d    = 1'b0;
        rdy_d   = 1'b0;
        cyc_d   = 1'b1;
        addr_d  = A_X;
        dat_d   = {2'b00, dx};
        state_d = S_PX;
      end
    end
  end

  assign rx_ready_o = rdy_q;
  assign busy_o     = ~rdy_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_we_o    = cyc_q;
  assign wb_addr_o  = addr_q;
  assign wb_dat_o   = dat_q;
  assign cursor_x_o = x_q;
  assign cursor_y_o = y_q;

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed testbench for vga_term_ctrl at default parameters (64x32).
module tb_vga_term_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       wb_cyc;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_dat;
  logic [5:0] cx;
  logic [4:0] cy;
  logic       busy;

  vga_term_ctrl #(.COLS(64), .ROWS(32), .CLR_CHAR(8'h20)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .wb_cyc_o   (wb_cyc),
    .wb_we_o    (wb_we),
    .wb_addr_o  (wb_addr),
    .wb_dat_o   (wb_dat),
    .cursor_x_o (cx),
    .cursor_y_o (cy),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  int          wr_cnt   = 0;
  int          sel_cnt  = 0;
  int          ch_non20 = 0;
  int          we_bad   = 0;
  int          busy_bad = 0;
  int          cyc_n    = 0;
  logic [10:0] log_w [6];
  int          log_t [6];

  always @(negedge clk) begin
    cyc_n++;
    if (wb_we !== wb_cyc) we_bad++;
    if (busy === rx_ready) busy_bad++;
    if (wb_cyc === 1'b1) begin
      wr_cnt++;
      if (wb_addr == 3'b110) sel_cnt++;
      if (wb_addr == 3'b000 && wb_dat != 8'h20) ch_non20++;
      for (int i = 5; i > 0; i--) begin
        log_w[i] = log_w[i-1];
        log_t[i] = log_t[i-1];
      end
      log_w[0] = {wb_addr, wb_dat};
      log_t[0] = cyc_n;
    end
  end

  int b_wr, b_sel, b_non;

  task automatic snap();
    b_wr  = wr_cnt;
    b_sel = sel_cnt;
    b_non = ch_non20;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'hFF;
  endtask

  task automatic wait_rdy(input string tag, input int lim, output int n);
    n = 0;
    while (rx_ready !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) chk({tag, "_timeout"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic put(input logic [7:0] b);
    int n;
    send(b);
    wait_rdy("put", 20, n);
  endtask

  task automatic chk_cur(input string tag, input logic [5:0] ex, input logic [4:0] ey);
    chk({tag, "_x"}, 32'(cx), 32'(ex));
    chk({tag, "_y"}, 32'(cy), 32'(ey));
  endtask

  int n;

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_addr", 32'(wb_addr), 32'd0);
    chk("rst_dat", 32'(wb_dat), 32'd0);
    chk("rst_rdy", 32'(rx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_cur("rst", 6'd0, 5'd0);

    // First byte: charset select, full clear, then the character
    snap();
    send(8'h41);
    chk("first_busy", 32'(rx_ready), 32'd0);
    wait_rdy("first", 7000, n);
    chk("first_lat", 32'(n), 32'd6148);
    chk("first_wr", 32'(wr_cnt - b_wr), 32'd6148);
    chk("first_sel", 32'(sel_cnt - b_sel), 32'd1);
    chk("first_non20", 32'(ch_non20 - b_non), 32'd1);
    chk("first_l0", 32'(log_w[0]), 32'({3'b000, 8'h41}));
    chk("first_l1", 32'(log_w[1]), 32'({3'b011, 8'h00}));
    chk("first_l2", 32'(log_w[2]), 32'({3'b001, 8'h00}));
    chk("first_l3", 32'(log_w[3]), 32'({3'b000, 8'h20}));
    chk("first_l4", 32'(log_w[4]), 32'({3'b011, 8'h1F}));
    chk("first_l5", 32'(log_w[5]), 32'({3'b001, 8'h3F}));
    chk("first_consec", 32'(log_t[0] - log_t[3]), 32'd3);
    chk_cur("first", 6'd1, 5'd0);

    // CR and LF back to back: no bus traffic, ready stays high
    snap();
    rx_data  = 8'h0D;
    rx_valid = 1'b1;
    tick();
    chk("crlf_rdy1", 32'(rx_ready), 32'd1);
    rx_data = 8'h0A;
    tick();
    rx_valid = 1'b0;
    chk("crlf_rdy2", 32'(rx_ready), 32'd1);
    tick();
    chk("crlf_wr", 32'(wr_cnt - b_wr), 32'd0);
    chk_cur("crlf", 6'd0, 5'd1);

    // Walk to (63,31) and print with wrap to (0,0)
    repeat (30) put(8'h0A);
    repeat (63) put(8'h78);
    chk_cur("pre_wrap", 6'd63, 5'd31);
    snap();
    send(8'h42);
    wait_rdy("wrap", 20, n);
    chk("wrap_lat", 32'(n), 32'd3);
    chk("wrap_wr", 32'(wr_cnt - b_wr), 32'd3);
    chk("wrap_l2", 32'(log_w[2]), 32'({3'b001, 8'h3F}));
    chk("wrap_l1", 32'(log_w[1]), 32'({3'b011, 8'h1F}));
    chk("wrap_l0", 32'(log_w[0]), 32'({3'b000, 8'h42}));
    chk_cur("wrap", 6'd0, 5'd0);

    // Backspace at (5,2)
    repeat (2) put(8'h0A);
    repeat (5) put(8'h61);
    chk_cur("pre_bs", 6'd5, 5'd2);
    snap();
    put(8'h08);
    chk("bs_wr", 32'(wr_cnt - b_wr), 32'd3);
    chk("bs_l2", 32'(log_w[2]), 32'({3'b001, 8'h04}));
    chk("bs_l1", 32'(log_w[1]), 32'({3'b011, 8'h02}));
    chk("bs_l0", 32'(log_w[0]), 32'({3'b000, 8'h20}));
    chk_cur("bs", 6'd4, 5'd2);

    // Ignored codes, then backspace at column 0
    snap();
    put(8'h7F);
    put(8'h01);
    chk_cur("ign", 6'd4, 5'd2);
    put(8'h0D);
    put(8'h08);
    tick();
    chk("bs0_wr", 32'(wr_cnt - b_wr), 32'd0);
    chk("bs0_rdy", 32'(rx_ready), 32'd1);
    chk_cur("bs0", 6'd0, 5'd2);

    // Form feed at (10,7)
    repeat (5) put(8'h0A);
    repeat (10) put(8'h62);
    chk_cur("pre_ff", 6'd10, 5'd7);
    snap();
    send(8'h0C);
    wait_rdy("ff", 7000, n);
    chk("ff_lat", 32'(n), 32'd6144);
    chk("ff_wr", 32'(wr_cnt - b_wr), 32'd6144);
    chk("ff_sel", 32'(sel_cnt - b_sel), 32'd0);
    chk("ff_non20", 32'(ch_non20 - b_non), 32'd0);
    chk_cur("ff", 6'd0, 5'd0);

    // Reset during a clear
    put(8'h5A);
    send(8'h0C);
    repeat (3000) tick();
    chk("mid_busy", 32'(rx_ready), 32'd0);
    chk_cur("mid", 6'd1, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cyc", 32'(wb_cyc), 32'd0);
    chk("abort_rdy", 32'(rx_ready), 32'd1);
    chk_cur("abort", 6'd0, 5'd0);
    snap();
    send(8'h55);
    wait_rdy("resplash", 7000, n);
    chk("resplash_wr", 32'(wr_cnt - b_wr), 32'd6148);
    chk("resplash_sel", 32'(sel_cnt - b_sel), 32'd1);
    chk("resplash_l0", 32'(log_w[0]), 32'({3'b000, 8'h55}));
    chk_cur("resplash", 6'd1, 5'd0);

    tick();
    chk("we_eq_cyc", 32'(we_bad), 32'd0);
    chk("busy_eq_nrdy", 32'(busy_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
